// File: rtl/led_seq_pkg.sv
// Shared types and default timing for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        CHASE  = 2'b00,
        BOUNCE = 2'b01,
        BLINK  = 2'b10,
        FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    localparam int DEF_DELAY_SLOW = 10_000_000;
    localparam int DEF_DELAY_FAST = 100_000;

endpackage

// File: rtl/led_pattern_sequencer_tick_prescaler.sv
// Step-rate prescaler: counts enabled cycles and fires one tick per step.
// The slow/fast choice is only reloaded on a tick, so a step is never cut short.
module tick_prescaler #(
    parameter int CTR_W      = 24,
    parameter int DELAY_SLOW = 10_000_000,
    parameter int DELAY_FAST = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic speed_s,
    output logic tick
);

    if (DELAY_SLOW < 2 || DELAY_FAST < 2) begin : g_bad_delay
        $error("tick_prescaler: DELAY_SLOW and DELAY_FAST must be >= 2");
    end
    if (CTR_W < 32 && ((DELAY_SLOW - 1) >= (1 << CTR_W) || (DELAY_FAST - 1) >= (1 << CTR_W))) begin : g_bad_ctr_w
        $error("tick_prescaler: CTR_W too narrow for the configured delays");
    end

    localparam logic [CTR_W-1:0] LAST_SLOW = CTR_W'(DELAY_SLOW - 1);
    localparam logic [CTR_W-1:0] LAST_FAST = CTR_W'(DELAY_FAST - 1);

    logic [CTR_W-1:0] ctr_reg;
    logic             fast_reg;   // active delay: 1 = DELAY_FAST, 0 = DELAY_SLOW
    logic [CTR_W-1:0] last_cnt;

    assign last_cnt = fast_reg ? LAST_FAST : LAST_SLOW;
    assign tick     = enable && (ctr_reg == last_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_reg  <= '0;
            fast_reg <= 1'b0;
        end else if (tick) begin
            ctr_reg  <= '0;
            fast_reg <= speed_s;
        end else if (enable) begin
            ctr_reg  <= ctr_reg + CTR_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// N-wide LED bank driver with chase, bounce, blink and fill patterns,
// a per-step toggle pin and a one-cycle step strobe.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int DELAY_SLOW = DEF_DELAY_SLOW,
    parameter int DELAY_FAST = DEF_DELAY_FAST,
    parameter int CTR_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              speed,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic              toggle_out,
    output logic              step_pulse
);

    if (N_LEDS < 2) begin : g_bad_n_leds
        $error("led_pattern_sequencer: N_LEDS must be >= 2");
    end

    localparam int                PW       = $clog2(N_LEDS + 1);
    localparam logic [PW-1:0]     POS_LAST = PW'(N_LEDS - 1);
    localparam logic [PW-1:0]     POS_FULL = PW'(N_LEDS);
    localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

    logic speed_meta_reg;
    logic speed_s_reg;
    logic tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_meta_reg <= 1'b0;
            speed_s_reg    <= 1'b0;
        end else begin
            speed_meta_reg <= speed;
            speed_s_reg    <= speed_meta_reg;
        end
    end

    tick_prescaler #(
        .CTR_W      (CTR_W),
        .DELAY_SLOW (DELAY_SLOW),
        .DELAY_FAST (DELAY_FAST)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .speed_s (speed_s_reg),
        .tick    (tick)
    );

    mode_e             mode_act_reg;
    dir_e              dir_reg;
    logic [PW-1:0]     pos_reg;
    logic              blink_ph_reg;
    logic [N_LEDS-1:0] led_reg;
    logic              toggle_reg;
    logic              step_pulse_reg;

    mode_e             mode_sel;
    logic [PW-1:0]     chase_next;
    logic [PW-1:0]     bounce_next;
    logic [PW-1:0]     fill_next;
    dir_e              bounce_dir_next;
    logic [N_LEDS-1:0] chase_frame;
    logic [N_LEDS-1:0] bounce_frame;
    logic [N_LEDS-1:0] fill_frame;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        chase_next      = (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);
        fill_next       = (pos_reg == POS_FULL) ? '0 : pos_reg + PW'(1);
        bounce_next     = (dir_reg == UP) ? pos_reg + PW'(1) : pos_reg - PW'(1);
        bounce_dir_next = dir_reg;
        // Turn around on arrival so the endpoint frame is shown only once.
        if (dir_reg == UP && bounce_next == POS_LAST)
            bounce_dir_next = DOWN;
        else if (dir_reg == DOWN && bounce_next == '0)
            bounce_dir_next = UP;
    end

    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_frame
        assign chase_frame[gi]  = (chase_next == PW'(gi));
        assign bounce_frame[gi] = (bounce_next == PW'(gi));
        assign fill_frame[gi]   = (PW'(gi) < fill_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_act_reg   <= CHASE;
            dir_reg        <= UP;
            pos_reg        <= '0;
            blink_ph_reg   <= 1'b0;
            led_reg        <= LED_ONE;
            toggle_reg     <= 1'b0;
            step_pulse_reg <= 1'b0;
        end else begin
            step_pulse_reg <= tick;
            if (tick) begin
                toggle_reg <= ~toggle_reg;
                if (mode_sel != mode_act_reg) begin
                    mode_act_reg <= mode_sel;
                    pos_reg      <= '0;
                    dir_reg      <= UP;
                    blink_ph_reg <= 1'b0;
                    led_reg      <= (mode_sel == CHASE || mode_sel == BOUNCE) ? LED_ONE : '0;
                end else begin
                    case (mode_act_reg)
                        CHASE: begin
                            pos_reg <= chase_next;
                            led_reg <= chase_frame;
                        end
                        BOUNCE: begin
                            pos_reg <= bounce_next;
                            dir_reg <= bounce_dir_next;
                            led_reg <= bounce_frame;
                        end
                        BLINK: begin
                            blink_ph_reg <= ~blink_ph_reg;
                            led_reg      <= blink_ph_reg ? '0 : '1;
                        end
                        default: begin
                            pos_reg <= fill_next;
                            led_reg <= fill_frame;
                        end
                    endcase
                end
            end
        end
    end

    assign led        = led_reg;
    assign toggle_out = toggle_reg;
    assign step_pulse = step_pulse_reg;

endmodule
